// File: rtl/cpu_ctrl_pkg.sv
// Shared control-bundle layout for the ID->EX->MEM->WB control pipeline.
package cpu_ctrl_pkg;

    localparam int CTRL_W_DEF = 8;
    localparam int REG_AW_DEF = 5;

    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_MEMREAD  = 5;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_ALUOP_HI = 2;
    localparam int CTRL_ALUOP_LO = 1;
    localparam int CTRL_REGDST   = 0;

    localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = 8'h00;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    // Anything that is not a solid 1 (0, X or Z) is stored as 0.
    function automatic logic clean_bit(input logic b);
        return (b === 1'b1);
    endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Bundle between the ID stage / datapath and the control pipeline.
interface ctrl_pipe_if #(
    parameter int CTRL_W = 8,
    parameter int REG_AW = 5
);
    logic [CTRL_W-1:0] id_ctrl_i;
    logic [REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0] id_rt_i;
    logic [REG_AW-1:0] id_rd_i;
    logic              flush_i;
    logic              stall_o;
    logic              ex_alusrc_o;
    logic [1:0]        ex_aluop_o;
    logic [REG_AW-1:0] ex_wreg_o;
    logic              mem_memread_o;
    logic              mem_memwrite_o;
    logic              mem_regwrite_o;
    logic [REG_AW-1:0] mem_wreg_o;
    logic              wb_regwrite_o;
    logic              wb_memtoreg_o;
    logic [REG_AW-1:0] wb_wreg_o;

    modport master (
        output id_ctrl_i, id_rs_i, id_rt_i, id_rd_i, flush_i,
        input  stall_o, ex_alusrc_o, ex_aluop_o, ex_wreg_o,
               mem_memread_o, mem_memwrite_o, mem_regwrite_o, mem_wreg_o,
               wb_regwrite_o, wb_memtoreg_o, wb_wreg_o
    );

    modport slave (
        input  id_ctrl_i, id_rs_i, id_rt_i, id_rd_i, flush_i,
        output stall_o, ex_alusrc_o, ex_aluop_o, ex_wreg_o,
               mem_memread_o, mem_memwrite_o, mem_regwrite_o, mem_wreg_o,
               wb_regwrite_o, wb_memtoreg_o, wb_wreg_o
    );

endinterface

// File: rtl/ctrl_stage_reg.sv
// Pipeline stage register: async active-low clear, synchronous bubble load.
module ctrl_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         bubble_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = bubble_i ? '0 : d_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline ID/EX -> EX/MEM -> MEM/WB with load-use hazard detection.
module ctrl_pipe
    import cpu_ctrl_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input logic         clk_i,
    input logic         rst_i,
    ctrl_pipe_if.slave  bus
);

    localparam int IDEX_W  = CTRL_W + 3 * REG_AW;
    localparam int EXMEM_W = 4 + REG_AW;
    localparam int MEMWB_W = 2 + REG_AW;

    logic [CTRL_W-1:0]  ctrl_clean;
    logic [REG_AW-1:0]  rs_clean;
    logic [REG_AW-1:0]  rt_clean;
    logic [REG_AW-1:0]  rd_clean;
    logic [IDEX_W-1:0]  idex_d;
    logic [IDEX_W-1:0]  idex_q;
    logic [EXMEM_W-1:0] exmem_d;
    logic [EXMEM_W-1:0] exmem_q;
    logic [MEMWB_W-1:0] memwb_d;
    logic [MEMWB_W-1:0] memwb_q;

    logic [CTRL_W-1:0]  ex_ctrl;
    logic [REG_AW-1:0]  ex_rs_unused;
    logic [REG_AW-1:0]  ex_rt;
    logic [REG_AW-1:0]  ex_rd;
    logic [REG_AW-1:0]  ex_wreg;
    logic               stall;
    logic               idex_bubble;

    logic               mem_regwrite;
    logic               mem_memtoreg;
    logic               mem_memread;
    logic               mem_memwrite;
    logic [REG_AW-1:0]  mem_wreg;

    // Sanitise at capture so no X, stale dest or stray MemtoReg travels down the pipe.
    always_comb begin
        for (int i = 0; i < CTRL_W; i++) begin
            ctrl_clean[i] = clean_bit(bus.id_ctrl_i[i]);
        end
        for (int i = 0; i < REG_AW; i++) begin
            rs_clean[i] = clean_bit(bus.id_rs_i[i]);
            rt_clean[i] = clean_bit(bus.id_rt_i[i]);
            rd_clean[i] = clean_bit(bus.id_rd_i[i]);
        end
        if (!ctrl_clean[CTRL_MEMREAD] && !ctrl_clean[CTRL_MEMWRITE]) begin
            ctrl_clean[CTRL_MEMTOREG] = 1'b0;
        end
        if (!ctrl_clean[CTRL_REGWRITE]) begin
            rt_clean = '0;
            rd_clean = '0;
        end
        idex_d = {ctrl_clean, rs_clean, rt_clean, rd_clean};
    end

    assign idex_bubble = stall | bus.flush_i;

    ctrl_stage_reg #(.W(IDEX_W)) u_idex (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .bubble_i (idex_bubble),
        .d_i      (idex_d),
        .q_o      (idex_q)
    );

    assign {ex_ctrl, ex_rs_unused, ex_rt, ex_rd} = idex_q;
    assign ex_wreg = ex_ctrl[CTRL_REGDST] ? ex_rd : ex_rt;

    // Register 0 is never a real producer, so it cannot cause a stall.
    assign stall = ex_ctrl[CTRL_MEMREAD] && (ex_wreg != '0) &&
                   ((ex_wreg == bus.id_rs_i) || (ex_wreg == bus.id_rt_i));

    always_comb begin
        exmem_d = {ex_ctrl[CTRL_REGWRITE], ex_ctrl[CTRL_MEMTOREG],
                   ex_ctrl[CTRL_MEMREAD], ex_ctrl[CTRL_MEMWRITE], ex_wreg};
    end

    ctrl_stage_reg #(.W(EXMEM_W)) u_exmem (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .bubble_i (1'b0),
        .d_i      (exmem_d),
        .q_o      (exmem_q)
    );

    assign {mem_regwrite, mem_memtoreg, mem_memread, mem_memwrite, mem_wreg} = exmem_q;

    always_comb begin
        memwb_d = {mem_regwrite, mem_memtoreg, mem_wreg};
    end

    ctrl_stage_reg #(.W(MEMWB_W)) u_memwb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .bubble_i (1'b0),
        .d_i      (memwb_d),
        .q_o      (memwb_q)
    );

    assign bus.stall_o        = stall;
    assign bus.ex_alusrc_o    = ex_ctrl[CTRL_ALUSRC];
    assign bus.ex_aluop_o     = ex_ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
    assign bus.ex_wreg_o      = ex_wreg;
    assign bus.mem_memread_o  = mem_memread;
    assign bus.mem_memwrite_o = mem_memwrite;
    assign bus.mem_regwrite_o = mem_regwrite;
    assign bus.mem_wreg_o     = mem_wreg;
    assign {bus.wb_regwrite_o, bus.wb_memtoreg_o, bus.wb_wreg_o} = memwb_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: fixed vector table, reset sequences and random traffic vs a model.
module tb_ctrl_pipe;

    localparam logic [7:0] R_TYPE = 8'b10000101;
    localparam logic [7:0] LW     = 8'b11101000;
    localparam logic [7:0] SW     = 8'b00011000;
    localparam logic [7:0] IDLE   = 8'b00000000;

    // Flattened view of every DUT output, in a fixed order.
    typedef struct packed {
        logic       stall;
        logic       exAluSrc;
        logic [1:0] exAluOp;
        logic [4:0] exWreg;
        logic       memRead;
        logic       memWrite;
        logic       memRegWrite;
        logic [4:0] memWreg;
        logic       wbRegWrite;
        logic       wbMemToReg;
        logic [4:0] wbWreg;
    } out_t;

    typedef struct {
        logic [7:0] ctrl;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       flush;
        out_t       expOut;
        out_t       mask;
    } vec_t;

    // One instruction's worth of control, as the model sees it travelling down the pipe.
    typedef struct packed {
        logic       regWrite;
        logic       memToReg;
        logic       memRead;
        logic       memWrite;
        logic       aluSrc;
        logic [1:0] aluOp;
        logic [4:0] dest;
    } instr_t;

    logic   clk;
    logic   rstN;
    out_t   act;
    int     numChecks;
    int     numFails;
    vec_t   vecs[$];
    instr_t pipeQ[$];

    ctrl_pipe_if bus ();

    ctrl_pipe dut (
        .clk_i (clk),
        .rst_i (rstN),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Gather all outputs into one packed record for comparison.
    assign act = {bus.stall_o, bus.ex_alusrc_o, bus.ex_aluop_o, bus.ex_wreg_o,
                  bus.mem_memread_o, bus.mem_memwrite_o, bus.mem_regwrite_o, bus.mem_wreg_o,
                  bus.wb_regwrite_o, bus.wb_memtoreg_o, bus.wb_wreg_o};

    function automatic out_t mkOut(input logic st, input logic as, input logic [1:0] op,
                                   input logic [4:0] ew, input logic mr, input logic mw,
                                   input logic mrw, input logic [4:0] mwr, input logic wrw,
                                   input logic wmt, input logic [4:0] wwr);
        out_t o;
        o = {st, as, op, ew, mr, mw, mrw, mwr, wrw, wmt, wwr};
        return o;
    endfunction

    task automatic addVec(input logic [7:0] ctrl, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic flush, input logic wbMtCare,
                          input out_t expOut);
        vec_t v;
        v.ctrl   = ctrl;
        v.rs     = rs;
        v.rt     = rt;
        v.rd     = rd;
        v.flush  = flush;
        v.expOut = expOut;
        v.mask   = '1;
        v.mask.wbMemToReg = wbMtCare;
        vecs.push_back(v);
    endtask

    // Decode a control word into what the pipe should carry for it.
    function automatic instr_t decodeInstr(input logic [7:0] ctrl, input logic [4:0] rt,
                                           input logic [4:0] rd);
        instr_t i;
        i.regWrite = ctrl[7];
        i.memRead  = ctrl[5];
        i.memWrite = ctrl[4];
        i.memToReg = (ctrl[5] | ctrl[4]) & ctrl[6];
        i.aluSrc   = ctrl[3];
        i.aluOp    = ctrl[2:1];
        if (!ctrl[7])     i.dest = 5'd0;
        else if (ctrl[0]) i.dest = rd;
        else              i.dest = rt;
        return i;
    endfunction

    // Expected outputs given the three in-flight instructions and the current ID sources.
    function automatic out_t modelOut(input logic [4:0] rs, input logic [4:0] rt);
        out_t   o;
        instr_t ex;
        instr_t mem;
        instr_t wb;
        ex  = pipeQ[0];
        mem = pipeQ[1];
        wb  = pipeQ[2];
        o.stall       = ex.memRead && (ex.dest != 5'd0) && ((ex.dest == rs) || (ex.dest == rt));
        o.exAluSrc    = ex.aluSrc;
        o.exAluOp     = ex.aluOp;
        o.exWreg      = ex.dest;
        o.memRead     = mem.memRead;
        o.memWrite    = mem.memWrite;
        o.memRegWrite = mem.regWrite;
        o.memWreg     = mem.dest;
        o.wbRegWrite  = wb.regWrite;
        o.wbMemToReg  = wb.memToReg;
        o.wbWreg      = wb.dest;
        return o;
    endfunction

    task automatic modelStep(input logic [7:0] ctrl, input logic [4:0] rt, input logic [4:0] rd,
                             input logic flush, input logic stall);
        instr_t n;
        n = (flush || stall) ? '0 : decodeInstr(ctrl, rt, rd);
        pipeQ.push_front(n);
        void'(pipeQ.pop_back());
    endtask

    task automatic modelReset();
        pipeQ.delete();
        repeat (3) pipeQ.push_back('0);
    endtask

    task automatic applyStimulus(input logic [7:0] ctrl, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] rd, input logic flush);
        bus.id_ctrl_i = ctrl;
        bus.id_rs_i   = rs;
        bus.id_rt_i   = rt;
        bus.id_rd_i   = rd;
        bus.flush_i   = flush;
    endtask

    task automatic checkOutput(input string name, input out_t got, input out_t expOut,
                               input out_t mask);
        numChecks++;
        if ((got & mask) !== (expOut & mask)) begin
            numFails++;
            $display("[TB] FAIL %s: got %h expected %h (mask %h)", name, got, expOut, mask);
        end
    endtask

    // One model-checked cycle: drive, compare mid-cycle, advance the model, step the clock.
    task automatic modelCycle(input string name, input logic [7:0] ctrl, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd, input logic flush,
                              output logic stallSeen);
        out_t e;
        applyStimulus(ctrl, rs, rt, rd, flush);
        @(negedge clk);
        e = modelOut(rs, rt);
        checkOutput(name, act, e, '1);
        modelStep(ctrl, rt, rd, flush, e.stall);
        stallSeen = e.stall;
        @(posedge clk);
        #1;
    endtask

    // Main sequence: reset, vector table, random traffic, mid-flight reset.
    initial begin
        logic [7:0]  ctrl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        flush;
        logic        stallSeen;
        logic [31:0] r;

        numChecks = 0;
        numFails  = 0;
        rstN      = 1'b0;
        applyStimulus(IDLE, 5'd0, 5'd0, 5'd0, 1'b0);
        modelReset();

        #3;
        checkOutput("resetState", act, '0, '1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("idleAfterRelease", act, '0, '1);
        @(posedge clk);
        #1;

        // Hand-derived vectors: R-type, load-use, $0 load, sw with X, flush, back-to-back loads.
        addVec(R_TYPE,     5'd1,  5'd2,  5'd3, 1'b0, 1'b1, mkOut(0,0,2'd0,5'd0,  0,0,0,5'd0,  0,0,5'd0));
        addVec(LW,         5'd0,  5'd5,  5'd0, 1'b0, 1'b1, mkOut(0,0,2'd2,5'd3,  0,0,0,5'd0,  0,0,5'd0));
        addVec(R_TYPE,     5'd5,  5'd6,  5'd7, 1'b0, 1'b1, mkOut(1,1,2'd0,5'd5,  0,0,1,5'd3,  0,0,5'd0));
        addVec(R_TYPE,     5'd5,  5'd6,  5'd7, 1'b0, 1'b1, mkOut(0,0,2'd0,5'd0,  1,0,1,5'd5,  1,0,5'd3));
        addVec(IDLE,       5'd0,  5'd0,  5'd0, 1'b0, 1'b1, mkOut(0,0,2'd2,5'd7,  0,0,0,5'd0,  1,1,5'd5));
        addVec(LW,         5'd0,  5'd0,  5'd0, 1'b0, 1'b1, mkOut(0,0,2'd0,5'd0,  0,0,1,5'd7,  0,0,5'd0));
        addVec(R_TYPE,     5'd0,  5'd0,  5'd4, 1'b0, 1'b1, mkOut(0,1,2'd0,5'd0,  0,0,0,5'd0,  1,0,5'd7));
        addVec(IDLE,       5'd0,  5'd0,  5'd0, 1'b0, 1'b1, mkOut(0,0,2'd2,5'd4,  1,0,1,5'd0,  0,0,5'd0));
        addVec(8'b0X01100X,5'd2,  5'd7,  5'd1, 1'b0, 1'b1, mkOut(0,0,2'd0,5'd0,  0,0,1,5'd4,  1,1,5'd0));
        addVec(IDLE,       5'd0,  5'd0,  5'd0, 1'b0, 1'b1, mkOut(0,1,2'd0,5'd0,  0,0,0,5'd0,  1,0,5'd4));
        addVec(IDLE,       5'd0,  5'd0,  5'd0, 1'b0, 1'b1, mkOut(0,0,2'd0,5'd0,  0,1,0,5'd0,  0,0,5'd0));
        addVec(IDLE,       5'd0,  5'd0,  5'd0, 1'b0, 1'b0, mkOut(0,0,2'd0,5'd0,  0,0,0,5'd0,  0,0,5'd0));
        addVec(LW,         5'd0,  5'd9,  5'd0, 1'b1, 1'b1, mkOut(0,0,2'd0,5'd0,  0,0,0,5'd0,  0,0,5'd0));
        addVec(R_TYPE,     5'd9,  5'd1,  5'd2, 1'b0, 1'b1, mkOut(0,0,2'd0,5'd0,  0,0,0,5'd0,  0,0,5'd0));
        addVec(LW,         5'd0,  5'd10, 5'd0, 1'b0, 1'b1, mkOut(0,0,2'd2,5'd2,  0,0,0,5'd0,  0,0,5'd0));
        addVec(R_TYPE,     5'd10, 5'd0,  5'd3, 1'b1, 1'b1, mkOut(1,1,2'd0,5'd10, 0,0,1,5'd2,  0,0,5'd0));
        addVec(R_TYPE,     5'd10, 5'd0,  5'd3, 1'b0, 1'b1, mkOut(0,0,2'd0,5'd0,  1,0,1,5'd10, 1,0,5'd2));
        addVec(IDLE,       5'd0,  5'd0,  5'd0, 1'b0, 1'b1, mkOut(0,0,2'd2,5'd3,  0,0,0,5'd0,  1,1,5'd10));
        addVec(LW,         5'd0,  5'd4,  5'd0, 1'b0, 1'b1, mkOut(0,0,2'd0,5'd0,  0,0,1,5'd3,  0,0,5'd0));
        addVec(LW,         5'd4,  5'd4,  5'd0, 1'b0, 1'b1, mkOut(1,1,2'd0,5'd4,  0,0,0,5'd0,  1,0,5'd3));
        addVec(LW,         5'd4,  5'd4,  5'd0, 1'b0, 1'b1, mkOut(0,0,2'd0,5'd0,  1,0,1,5'd4,  0,0,5'd0));
        addVec(R_TYPE,     5'd4,  5'd0,  5'd6, 1'b0, 1'b1, mkOut(1,1,2'd0,5'd4,  0,0,0,5'd0,  1,1,5'd4));
        addVec(R_TYPE,     5'd4,  5'd0,  5'd6, 1'b0, 1'b1, mkOut(0,0,2'd0,5'd0,  1,0,1,5'd4,  0,0,5'd0));
        addVec(IDLE,       5'd0,  5'd0,  5'd0, 1'b0, 1'b1, mkOut(0,0,2'd2,5'd6,  0,0,0,5'd0,  1,1,5'd4));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ctrl, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].flush);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), act, vecs[i].expOut, vecs[i].mask);
            @(posedge clk);
            #1;
        end

        // Flush the table's leftovers so the model starts from an empty pipe.
        repeat (3) begin
            applyStimulus(IDLE, 5'd0, 5'd0, 5'd0, 1'b0);
            @(posedge clk);
            #1;
        end
        modelReset();

        // Random traffic; a stalled instruction is held in ID like a real front end would.
        stallSeen = 1'b0;
        ctrl = IDLE; rs = '0; rt = '0; rd = '0;
        for (int n = 0; n < 300; n++) begin
            if (!stallSeen) begin
                r = $urandom;
                case ($urandom_range(0, 3))
                    0:       ctrl = LW;
                    1:       ctrl = R_TYPE;
                    2:       ctrl = SW;
                    default: ctrl = r[7:0];
                endcase
                rs = 5'($urandom_range(0, 7));
                rt = 5'($urandom_range(0, 7));
                rd = 5'($urandom_range(0, 7));
            end
            flush = ($urandom_range(0, 7) == 0);
            modelCycle("random", ctrl, rs, rt, rd, flush, stallSeen);
        end

        // Fill the pipe with writers, then pull reset mid-cycle.
        for (int n = 1; n <= 3; n++) begin
            modelCycle("preReset", R_TYPE, 5'd0, 5'd0, 5'(n), 1'b0, stallSeen);
        end
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("asyncReset", act, '0, '1);
        applyStimulus(IDLE, 5'd0, 5'd0, 5'd0, 1'b0);
        modelReset();
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 3; n++) begin
            modelCycle("postReset", IDLE, 5'd0, 5'd0, 5'd0, 1'b0, stallSeen);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
